// File: rtl/ts_serial_tx_pkg.sv
// ts_serial_tx_pkg: shared TS constants and the buffer reader state encoding
// Also used by the EP2 control reader, which follows the same arm/ack handshake.
package ts_serial_tx_pkg;
   localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
   localparam int TS_PKT_LEN = 188;
   typedef enum logic [2:0] {R_IDLE, R_ADDR, R_WAIT, R_HOLD, R_ARM} rd_state_t;
endpackage

// File: rtl/ts_serial_tx_buf_out_reader.sv
// ts_serial_tx_buf_out_reader: drains an OUT endpoint buffer into a one-byte holding register
// Ports: clk/reset; buf_out_* endpoint buffer read and arm/ack handshake;
//        byte_data/byte_valid hold the fetched byte until byte_ready consumes it;
//        idle is high when no buffer is in progress.
module ts_serial_tx_buf_out_reader
   import ts_serial_tx_pkg::*;
#(
   parameter int RD_LAT = 2,
   parameter int BUF_MAX = 512
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       buf_out_hasdata,
   input  logic [9:0] buf_out_len,
   input  logic [7:0] buf_out_q,
   output logic [8:0] buf_out_addr,
   output logic       buf_out_arm,
   input  logic       buf_out_arm_ack,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       idle
);
   localparam logic [3:0] LAT = 4'(RD_LAT);
   localparam logic [9:0] MAXL = 10'(BUF_MAX);
   rd_state_t st;
   logic [9:0] len, idx;
   logic [3:0] wcnt;
   logic s1, s2, s3;
   assign idle = st == R_IDLE;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         st <= R_IDLE;
         len <= '0;
         idx <= '0;
         wcnt <= '0;
         buf_out_addr <= '0;
         buf_out_arm <= 1'b0;
         byte_data <= '0;
         byte_valid <= 1'b0;
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         // ack comes from another clock domain: two-flop sync plus an edge register
         s1 <= buf_out_arm_ack;
         s2 <= s1;
         s3 <= s2;
         case (st)
            R_IDLE:
               if (buf_out_hasdata) begin
                  len <= buf_out_len > MAXL ? MAXL : buf_out_len;
                  idx <= '0;
                  st <= buf_out_len == '0 ? R_ARM : R_ADDR;
                  buf_out_arm <= buf_out_len == '0;
               end
            R_ADDR: begin
               buf_out_addr <= idx[8:0];
               wcnt <= '0;
               st <= R_WAIT;
            end
            R_WAIT:
               if (wcnt == LAT) begin
                  byte_data <= buf_out_q;
                  byte_valid <= 1'b1;
                  st <= R_HOLD;
               end else wcnt <= wcnt + 1'b1;
            R_HOLD:
               if (byte_ready) begin
                  byte_valid <= 1'b0;
                  idx <= idx + 1'b1;
                  st <= idx + 1'b1 == len ? R_ARM : R_ADDR;
                  buf_out_arm <= idx + 1'b1 == len;
               end
            R_ARM:
               if (s2 && !s3) begin
                  buf_out_arm <= 1'b0;
                  st <= R_IDLE;
               end
            default: st <= R_IDLE;
         endcase
      end
endmodule

// File: rtl/ts_serial_tx.sv
// ts_serial_tx: serializes host-written OUT buffer bytes as a 188-byte MPEG-TS serial stream
// Ports: clk/reset; enable allows a new packet to start; buf_out_* endpoint buffer
//        interface; ts_clk/ts_data/ts_valid/ts_start serial TS output (MSB first,
//        data valid on ts_clk rising); busy, pkt_cnt (wraps), drop_cnt (saturates).
module ts_serial_tx
   import ts_serial_tx_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int RD_LAT = 2,
   parameter int BUF_MAX = 512
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        buf_out_hasdata,
   input  logic [9:0]  buf_out_len,
   input  logic [7:0]  buf_out_q,
   output logic [8:0]  buf_out_addr,
   output logic        buf_out_arm,
   input  logic        buf_out_arm_ack,
   output logic        ts_clk,
   output logic        ts_data,
   output logic        ts_valid,
   output logic        ts_start,
   output logic        busy,
   output logic [15:0] pkt_cnt,
   output logic [15:0] drop_cnt
);
   localparam logic [7:0] DIVM = 8'(CLK_DIV - 1);
   localparam logic [7:0] PKTM = 8'(TS_PKT_LEN - 1);
   logic [7:0] dcnt, hold, sh, pbc;
   logic [3:0] bits;
   logic full, idle, fall, hunt, load, stb, lst;
   ts_serial_tx_buf_out_reader #(.RD_LAT(RD_LAT), .BUF_MAX(BUF_MAX)) u_buf_out_reader (
      .clk(clk),
      .reset(reset),
      .buf_out_hasdata(buf_out_hasdata),
      .buf_out_len(buf_out_len),
      .buf_out_q(buf_out_q),
      .buf_out_addr(buf_out_addr),
      .buf_out_arm(buf_out_arm),
      .buf_out_arm_ack(buf_out_arm_ack),
      .byte_data(hold),
      .byte_valid(full),
      .byte_ready(hunt || load),
      .idle(idle)
   );
   assign fall = ts_clk && dcnt == DIVM;
   // out-of-sync bytes at a packet boundary are discarded without waiting for a bit slot
   assign hunt = full && pbc == '0 && hold != TS_SYNC_BYTE;
   assign load = full && fall && bits == '0 && (pbc != '0 || (enable && hold == TS_SYNC_BYTE));
   assign busy = !idle || bits != '0 || pbc != '0;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         dcnt <= '0;
         ts_clk <= 1'b0;
         ts_data <= 1'b0;
         ts_valid <= 1'b0;
         ts_start <= 1'b0;
         sh <= '0;
         bits <= '0;
         stb <= 1'b0;
         lst <= 1'b0;
         pbc <= '0;
         pkt_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         dcnt <= dcnt == DIVM ? '0 : dcnt + 1'b1;
         if (dcnt == DIVM) ts_clk <= !ts_clk;
         if (hunt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
         if (fall) begin
            // the final byte of a packet counts once its eighth bit period is over
            if (bits == '0 && lst) begin
               pkt_cnt <= pkt_cnt + 1'b1;
               lst <= 1'b0;
            end
            if (bits != '0) begin
               ts_data <= sh[7];
               sh <= {sh[6:0], 1'b0};
               bits <= bits - 1'b1;
               ts_valid <= 1'b1;
               ts_start <= stb;
            end else if (load) begin
               ts_data <= hold[7];
               sh <= {hold[6:0], 1'b0};
               bits <= 4'd7;
               ts_valid <= 1'b1;
               ts_start <= pbc == '0;
               stb <= pbc == '0;
               lst <= pbc == PKTM;
               pbc <= pbc == PKTM ? '0 : pbc + 1'b1;
            end else begin
               ts_data <= 1'b0;
               ts_valid <= 1'b0;
               ts_start <= 1'b0;
            end
         end
      end
endmodule

// File: tb/tb_ts_serial_tx.sv
// tb_ts_serial_tx: directed self-checking bench for ts_serial_tx
module tb_ts_serial_tx;
   typedef struct {
      int junk;
      int len1;
      int ack_dly;
      int exp_drop;
      int exp_gap;
      int exp_addr;
   } vec_t;
   logic clk = 1'b0, reset = 1'b1, enable = 1'b0, buf_out_hasdata = 1'b0, buf_out_arm_ack = 1'b0;
   logic [9:0] buf_out_len = '0;
   logic [7:0] buf_out_q, p1;
   logic [8:0] buf_out_addr;
   logic buf_out_arm, ts_clk, ts_data, ts_valid, ts_start, busy;
   logic [15:0] pkt_cnt, drop_cnt;
   logic [7:0] mem [512];
   logic [7:0] rx [$];
   logic [7:0] rsh;
   int n_cmp = 0, n_err = 0;
   int rbits, nbits, nstart, bp, first_bp, last_bp, bad_idle, bad_start;
   int arm_addr, arm_lat, ack_lat;
   bit abort = 0, done = 0;
   vec_t tbl [3];

   ts_serial_tx dut (
      .clk(clk), .reset(reset), .enable(enable),
      .buf_out_hasdata(buf_out_hasdata), .buf_out_len(buf_out_len), .buf_out_q(buf_out_q),
      .buf_out_addr(buf_out_addr), .buf_out_arm(buf_out_arm), .buf_out_arm_ack(buf_out_arm_ack),
      .ts_clk(ts_clk), .ts_data(ts_data), .ts_valid(ts_valid), .ts_start(ts_start),
      .busy(busy), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      p1 <= mem[buf_out_addr];
      buf_out_q <= p1;
   end

   initial forever begin
      @(posedge ts_clk);
      #1;
      bp++;
      if (ts_valid) begin
         if (nbits == 0) first_bp = bp;
         last_bp = bp;
         nbits++;
         if (ts_start) begin
            nstart++;
            if (rx.size() != 0) bad_start++;
         end
         rsh = {rsh[6:0], ts_data};
         rbits++;
         if (rbits == 8) begin
            rx.push_back(rsh);
            rbits = 0;
         end
      end else if (ts_data || ts_start) bad_idle++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      rx.delete();
      rbits = 0; nbits = 0; nstart = 0; bp = 0;
      first_bp = 0; last_bp = 0; bad_idle = 0; bad_start = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      buf_out_hasdata = 1'b0;
      buf_out_arm_ack = 1'b0;
      step(2);
      clear_mon();
      abort = 0;
      reset = 1'b0;
      step(1);
   endtask

   task automatic send_buf(input int len, input int dly);
      int n;
      buf_out_len = 10'(len);
      buf_out_hasdata = 1'b1;
      for (n = 0; n < 30000 && !buf_out_arm && !abort; n++) step(1);
      if (abort) begin
         buf_out_hasdata = 1'b0;
         return;
      end
      chk("arm_rise", buf_out_arm, 1);
      arm_addr = buf_out_addr;
      arm_lat = n;
      step(dly);
      buf_out_arm_ack = 1'b1;
      buf_out_hasdata = 1'b0;
      for (n = 0; n < 20 && buf_out_arm; n++) step(1);
      ack_lat = n;
      chk("arm_fall", buf_out_arm, 0);
      buf_out_arm_ack = 1'b0;
      step(3);
   endtask

   task automatic load_stream(input int junk, output int total);
      logic [7:0] jk [3];
      logic [7:0] s [$];
      jk = '{8'h00, 8'hFF, 8'h12};
      for (int i = 0; i < junk; i++) s.push_back(jk[i]);
      s.push_back(8'h47);
      for (int i = 0; i < 187; i++) s.push_back(8'(i));
      total = s.size();
      for (int i = 0; i < total; i++) mem[i] = s[i];
   endtask

   task automatic check_pkt(input string nm);
      int bad = 0;
      for (int i = 0; i < rx.size() && i < 188; i++)
         if (rx[i] !== (i == 0 ? 8'h47 : 8'(i - 1))) bad++;
      chk({nm, "_rx_len"}, rx.size(), 188);
      chk({nm, "_rx_bytes"}, bad, 0);
      chk({nm, "_nbits"}, nbits, 1504);
      chk({nm, "_nstart"}, nstart, 8);
      chk({nm, "_start_late"}, bad_start, 0);
      chk({nm, "_idle_data"}, bad_idle, 0);
      chk({nm, "_pkt_cnt"}, pkt_cnt, 1);
      chk({nm, "_busy_end"}, busy, 0);
      chk({nm, "_valid_end"}, ts_valid, 0);
   endtask

   task automatic run_vec(input vec_t v, input bit rst);
      int total, l1, n;
      logic [7:0] tail [$];
      if (rst) do_reset();
      clear_mon();
      enable = 1'b1;
      load_stream(v.junk, total);
      l1 = v.len1;
      for (int i = l1; i < total; i++) tail.push_back(mem[i]);
      send_buf(l1, v.ack_dly);
      if (l1 < total) begin
         for (int i = 0; i < total - l1; i++) mem[i] = tail[i];
         send_buf(total - l1, 2);
      end
      chk("last_arm_addr", arm_addr, v.exp_addr);
      chk("ack_to_arm_low", ack_lat, 3);
      for (n = 0; n < 2000 && pkt_cnt == 0; n++) step(1);
      step(8);
      check_pkt("vec");
      chk("vec_drop_cnt", drop_cnt, v.exp_drop);
      chk("vec_gap", (last_bp - first_bp + 1) != nbits, v.exp_gap);
   endtask

   initial begin
      int total, n, prev;
      bit pc;
      tbl[0] = '{0, 188, 2, 0, 0, 187};
      tbl[1] = '{0, 100, 40, 0, 1, 87};
      tbl[2] = '{3, 191, 2, 3, 0, 190};
      clear_mon();
      step(2);
      chk("rst_ts_clk", ts_clk, 0);
      chk("rst_ts_valid", ts_valid, 0);
      chk("rst_ts_start", ts_start, 0);
      chk("rst_ts_data", ts_data, 0);
      chk("rst_arm", buf_out_arm, 0);
      chk("rst_addr", buf_out_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      chk("rst_drop_cnt", drop_cnt, 0);

      for (int i = 0; i < 3; i++) run_vec(tbl[i], 1);

      clear_mon();
      prev = buf_out_addr;
      send_buf(0, 3);
      chk("zl_arm_latency", arm_lat, 1);
      chk("zl_no_read", buf_out_addr, prev);
      chk("zl_no_bits", nbits, 0);
      chk("zl_busy", busy, 0);

      do_reset();
      enable = 1'b0;
      load_stream(0, total);
      done = 0;
      fork
         begin
            send_buf(total, 2);
            done = 1;
         end
      join_none
      step(200);
      chk("en_hold_bits", nbits, 0);
      chk("en_hold_valid", ts_valid, 0);
      chk("en_hold_busy", busy, 1);
      enable = 1'b1;
      pc = ts_clk;
      for (n = 0; n < 20; n++) begin
         step(1);
         if (pc && !ts_clk) break;
         pc = ts_clk;
      end
      chk("en_first_fall_valid", ts_valid, 1);
      chk("en_first_fall_start", ts_start, 1);
      for (n = 0; n < 5000 && rx.size() < 50; n++) step(1);
      enable = 1'b0;
      for (n = 0; n < 8000 && !(done && pkt_cnt != 0); n++) step(1);
      step(8);
      check_pkt("en");

      clear_mon();
      enable = 1'b1;
      load_stream(1, total);
      fork
         send_buf(total, 2);
      join_none
      for (n = 0; n < 8000 && rx.size() < 90; n++) step(1);
      chk("mr_pre_drop", drop_cnt, 1);
      chk("mr_pre_valid", ts_valid, 1);
      reset = 1'b1;
      abort = 1;
      #1;
      chk("mr_valid", ts_valid, 0);
      chk("mr_start", ts_start, 0);
      chk("mr_ts_clk", ts_clk, 0);
      chk("mr_data", ts_data, 0);
      chk("mr_arm", buf_out_arm, 0);
      chk("mr_busy", busy, 0);
      chk("mr_pkt_cnt", pkt_cnt, 0);
      chk("mr_drop_cnt", drop_cnt, 0);
      step(3);
      abort = 0;
      reset = 1'b0;
      step(2);
      chk("mr_post_pkt_cnt", pkt_cnt, 0);
      chk("mr_post_drop_cnt", drop_cnt, 0);
      run_vec(tbl[2], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
